// File: rtl/rf_pkg.sv
// Shared register-file constants and address-width helper for the core's decode/hazard logic.
// No logic of its own; sizes only.
// No flow control.
package rf_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;

    // A one-entry file still needs a one-bit address to keep port slices legal.
    function automatic int addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: alloc sets, writeback clears, alloc wins on the same address.
// Latency: busy_vec reflects an edge's set/clear right after that edge.
// No backpressure; one outstanding producer per register.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = addr_w(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WR-1:0]    clr_en,
    input  logic [NUM_WR*AW-1:0] clr_addr,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    output logic [NUM_REGS-1:0]  busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (clr_en[j]) busy_nxt[clr_addr[j*AW +: AW]] = 1'b0;
        end
        // The newly issued producer supersedes any retiring one.
        if (alloc_en) busy_nxt[alloc_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_nxt;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with busy scoreboard and optional write-to-read bypass.
// Latency: reads are combinational; writes land on the rising edge.
// No backpressure; decode stalls externally on rd_busy.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [NUM_WR-1:0] wr_live;
    logic              alloc_live;

    // Writes and allocs aimed at a hardwired zero register are dropped outright.
    always_comb begin
        wr_live = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_live[j] = wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*AW +: AW] == '0);
        end
        alloc_live = alloc_en && !(ZERO_REG != 0 && alloc_addr == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
        end else begin
            // Later ports overwrite earlier ones: highest index wins a conflict.
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_live[j]) mem[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .clr_en     (wr_live),
        .clr_addr   (wr_addr),
        .alloc_en   (alloc_live),
        .alloc_addr (alloc_addr),
        .busy_vec   (busy_vec)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin : g_rd
            logic [AW-1:0]     a;
            logic [DATA_W-1:0] d;
            logic              b;
            logic              hit;
            a   = rd_addr[i*AW +: AW];
            d   = mem[a];
            b   = busy_vec[a];
            hit = 1'b0;
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_live[j] && wr_addr[j*AW +: AW] == a) begin
                        d   = wr_data[j*DATA_W +: DATA_W];
                        hit = 1'b1;
                    end
                end
                // A retiring producer frees the operand now unless a new one claims it.
                if (hit && !(alloc_live && alloc_addr == a)) b = 1'b0;
            end
            if (ZERO_REG != 0 && a == '0) begin
                d = '0;
                b = 1'b0;
            end
            rd_data[i*DATA_W +: DATA_W] = d;
            rd_busy[i]                  = b;
        end
    end

endmodule
